crc_stream_engine: RTL and testbench

CRC_STREAM_ENGINE -- requirements
Module: crc_stream_engine

---
 rtl/crc_stream_engine.sv | 193 +++++++++++++++++++
 tb/tb_crc_stream_engine.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/crc_stream_engine.sv
// Streaming CRC engine: accepts DATA_WIDTH-bit beats, folds every byte into a
// parameterised CRC register, then presents the final CRC and byte length.
// A partial final beat is drained one byte per cycle in the TAIL state.
module crc_stream_engine #(
  parameter int                   DATA_WIDTH = 16,
  parameter int                   CRC_WIDTH  = 16,
  parameter logic [CRC_WIDTH-1:0] POLY       = CRC_WIDTH'('h1021),
  parameter logic [CRC_WIDTH-1:0] INIT       = '1,
  parameter bit                   REFIN      = 1'b0,
  parameter bit                   REFOUT     = 1'b0,
  parameter logic [CRC_WIDTH-1:0] XOROUT     = '0
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    clr,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [DATA_WIDTH-1:0]   s_data,
  input  logic [DATA_WIDTH/8-1:0] s_keep,
  input  logic                    s_last,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [CRC_WIDTH-1:0]    m_crc,
  output logic [31:0]             m_len
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int KW    = $clog2(BYTES + 1);

  // Reject out-of-range configurations at elaboration time.
  if (DATA_WIDTH < 8 || DATA_WIDTH > 64 || (DATA_WIDTH % 8) != 0) begin : g_bad_data_width
    $error("crc_stream_engine: DATA_WIDTH must be a multiple of 8 in 8..64");
  end
  if (CRC_WIDTH < 8 || CRC_WIDTH > 32) begin : g_bad_crc_width
    $error("crc_stream_engine: CRC_WIDTH must be in 8..32");
  end

  typedef enum logic [1:0] {IDLE, ACCUM, TAIL, RESULT} state_t;

  state_t                  state_reg, state_next;
  logic [CRC_WIDTH-1:0]    crc_reg, crc_next;
  logic [31:0]             len_reg, len_next;
  logic [DATA_WIDTH-1:0]   tail_data_reg, tail_data_next;
  logic [KW-1:0]           tail_cnt_reg, tail_cnt_next;
  logic [CRC_WIDTH-1:0]    m_crc_reg, m_crc_next;
  logic [BYTES-1:0]        keep_prefix;

  // Fold one byte into the register, MSB-first on the (optionally reflected) byte.
  function automatic logic [CRC_WIDTH-1:0] crc_byte(input logic [CRC_WIDTH-1:0] c,
                                                    input logic [7:0] b);
    logic [CRC_WIDTH-1:0] r;
    logic [7:0]           d;
    logic                 fb;
    r = c;
    d = b;
    if (REFIN) begin
      for (int i = 0; i < 8; i++) d[i] = b[7-i];
    end
    for (int i = 7; i >= 0; i--) begin
      fb = r[CRC_WIDTH-1] ^ d[i];
      r  = {r[CRC_WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);
    end
    return r;
  endfunction

  // Fold a whole beat, byte 0 first.
  function automatic logic [CRC_WIDTH-1:0] crc_beat(input logic [CRC_WIDTH-1:0] c,
                                                    input logic [DATA_WIDTH-1:0] d);
    logic [CRC_WIDTH-1:0] r;
    r = c;
    for (int i = 0; i < BYTES; i++) r = crc_byte(r, d[8*i +: 8]);
    return r;
  endfunction

  // Output transform applied once when the result is captured.
  function automatic logic [CRC_WIDTH-1:0] crc_final(input logic [CRC_WIDTH-1:0] c);
    logic [CRC_WIDTH-1:0] r;
    r = c;
    if (REFOUT) begin
      for (int i = 0; i < CRC_WIDTH; i++) r[i] = c[CRC_WIDTH-1-i];
    end
    return r ^ XOROUT;
  endfunction

  // Length accumulator that sticks at 2^32-1.
  function automatic logic [31:0] len_add(input logic [31:0] l, input int unsigned n);
    logic [32:0] s;
    s = {1'b0, l} + 33'(n);
    return s[32] ? '1 : s[31:0];
  endfunction

  // Number of leading ones in a prefix mask.
  function automatic logic [KW-1:0] count_ones(input logic [BYTES-1:0] p);
    logic [KW-1:0] n;
    n = '0;
    for (int i = 0; i < BYTES; i++) n = n + KW'(p[i]);
    return n;
  endfunction

  // keep_prefix[i] is set only when bytes 0..i are all enabled, so its
  // population count is the run of ones starting at bit 0.
  for (genvar gi = 0; gi < BYTES; gi++) begin : g_keep
    assign keep_prefix[gi] = &s_keep[gi:0];
  end

  assign s_ready = rstn & ~clr & ((state_reg == IDLE) | (state_reg == ACCUM));
  assign m_valid = (state_reg == RESULT);
  assign m_crc   = m_crc_reg;
  assign m_len   = len_reg;

  // Next-state and datapath updates; clr overrides everything at the end.
  always_comb begin
    logic [CRC_WIDTH-1:0] base_crc;
    logic [31:0]          base_len;
    logic [CRC_WIDTH-1:0] step_crc;
    state_next     = state_reg;
    crc_next       = crc_reg;
    len_next       = len_reg;
    tail_data_next = tail_data_reg;
    tail_cnt_next  = tail_cnt_reg;
    m_crc_next     = m_crc_reg;
    base_crc       = (state_reg == IDLE) ? INIT : crc_reg;
    base_len       = (state_reg == IDLE) ? 32'd0 : len_reg;
    step_crc       = '0;
    case (state_reg)
      IDLE, ACCUM: begin
        if (s_valid && s_ready) begin
          if (!s_last || (&s_keep)) begin
            step_crc = crc_beat(base_crc, s_data);
            crc_next = step_crc;
            len_next = len_add(base_len, BYTES);
            if (s_last) begin
              state_next = RESULT;
              m_crc_next = crc_final(step_crc);
            end else begin
              state_next = ACCUM;
            end
          end else begin
            crc_next       = base_crc;
            len_next       = base_len;
            tail_data_next = s_data;
            tail_cnt_next  = count_ones(keep_prefix);
            state_next     = TAIL;
          end
        end
      end
      TAIL: begin
        step_crc = crc_reg;
        if (tail_cnt_reg != '0) begin
          step_crc       = crc_byte(crc_reg, tail_data_reg[7:0]);
          crc_next       = step_crc;
          tail_data_next = tail_data_reg >> 8;
          tail_cnt_next  = tail_cnt_reg - 1'b1;
          len_next       = len_add(len_reg, 1);
        end
        if (tail_cnt_reg <= KW'(1)) begin
          state_next = RESULT;
          m_crc_next = crc_final(step_crc);
        end
      end
      RESULT: begin
        if (m_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (clr) begin
      state_next    = IDLE;
      crc_next      = INIT;
      len_next      = '0;
      tail_cnt_next = '0;
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg     <= IDLE;
      crc_reg       <= INIT;
      len_reg       <= '0;
      tail_data_reg <= '0;
      tail_cnt_reg  <= '0;
      m_crc_reg     <= '0;
    end else begin
      state_reg     <= state_next;
      crc_reg       <= crc_next;
      len_reg       <= len_next;
      tail_data_reg <= tail_data_next;
      tail_cnt_reg  <= tail_cnt_next;
      m_crc_reg     <= m_crc_next;
    end
  end

endmodule

// File: tb/tb_crc_stream_engine.sv
// Testbench for crc_stream_engine: an 8-bit CRC-16/CCITT-FALSE instance (a_*)
// and a 32-bit CRC-32 instance (b_*), checked against bitwise reference CRCs.
module tb_crc_stream_engine;

  typedef logic [7:0] u8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;
  logic        a_clr, a_s_valid, a_s_ready, a_s_last, a_m_valid, a_m_ready;
  logic [7:0]  a_s_data;
  logic [0:0]  a_s_keep;
  logic [15:0] a_m_crc;
  logic [31:0] a_m_len;
  logic        b_clr, b_s_valid, b_s_ready, b_s_last, b_m_valid, b_m_ready;
  logic [31:0] b_s_data;
  logic [3:0]  b_s_keep;
  logic [31:0] b_m_crc;
  logic [31:0] b_m_len;

  int n_checks = 0;
  int n_fail   = 0;

  crc_stream_engine #(.DATA_WIDTH(8)) u_a (
    .clk(clk), .rstn(rstn), .clr(a_clr),
    .s_valid(a_s_valid), .s_ready(a_s_ready), .s_data(a_s_data),
    .s_keep(a_s_keep), .s_last(a_s_last),
    .m_valid(a_m_valid), .m_ready(a_m_ready), .m_crc(a_m_crc), .m_len(a_m_len)
  );

  crc_stream_engine #(
    .DATA_WIDTH(32), .CRC_WIDTH(32), .POLY(32'h04C11DB7), .INIT(32'hFFFFFFFF),
    .REFIN(1'b1), .REFOUT(1'b1), .XOROUT(32'hFFFFFFFF)
  ) u_b (
    .clk(clk), .rstn(rstn), .clr(b_clr),
    .s_valid(b_s_valid), .s_ready(b_s_ready), .s_data(b_s_data),
    .s_keep(b_s_keep), .s_last(b_s_last),
    .m_valid(b_m_valid), .m_ready(b_m_ready), .m_crc(b_m_crc), .m_len(b_m_len)
  );

  // Reference CRC-16/CCITT-FALSE, MSB-first shift register.
  function automatic logic [15:0] ref_crc16(input u8 m[$]);
    logic [15:0] c;
    c = 16'hFFFF;
    foreach (m[i]) begin
      c = c ^ {m[i], 8'h00};
      repeat (8) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    return c;
  endfunction

  // Reference CRC-32 (reflected form, LSB-first with reversed polynomial).
  function automatic logic [31:0] ref_crc32(input u8 m[$]);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (m[i]) begin
      c = c ^ {24'h0, m[i]};
      repeat (8) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  function automatic logic [31:0] ref_crc(input bit sel, input u8 m[$]);
    return sel ? ref_crc32(m) : {16'h0, ref_crc16(m)};
  endfunction

  function automatic logic get_rdy(input bit sel);
    return sel ? b_s_ready : a_s_ready;
  endfunction
  function automatic logic get_mv(input bit sel);
    return sel ? b_m_valid : a_m_valid;
  endfunction
  function automatic logic [31:0] get_crc(input bit sel);
    return sel ? b_m_crc : {16'h0, a_m_crc};
  endfunction
  function automatic logic [31:0] get_len(input bit sel);
    return sel ? b_m_len : a_m_len;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drop_valid(input bit sel);
    if (sel) begin b_s_valid = 1'b0; b_s_last = 1'b0; end
    else begin a_s_valid = 1'b0; a_s_last = 1'b0; end
  endtask

  // Present one beat at a negedge; returns once s_ready is seen, so the next
  // rising edge accepts it.
  task automatic drive_beat(input bit sel, input logic [31:0] d, input logic [3:0] k,
                            input logic l, input string tag);
    int t;
    @(negedge clk);
    if (sel) begin b_s_data = d; b_s_keep = k; b_s_last = l; b_s_valid = 1'b1; end
    else begin a_s_data = d[7:0]; a_s_keep = k[0:0]; a_s_last = l; a_s_valid = 1'b1; end
    t = 0;
    while (!get_rdy(sel) && t < 40) begin @(negedge clk); t++; end
    if (!get_rdy(sel)) chk({tag, "_ready_timeout"}, 64'(get_rdy(sel)), 64'd1);
  endtask

  // Wait for the result, check latency/value/length, optionally stall, then consume.
  task automatic expect_result(input bit sel, input logic [31:0] ec, input logic [31:0] el,
                               input int elat, input int hold, input string tag);
    int lat;
    lat = 0;
    do begin
      @(negedge clk);
      drop_valid(sel);
      lat++;
    end while (!get_mv(sel) && lat < 40);
    chk({tag, "_latency"}, 64'(lat), 64'(elat));
    chk({tag, "_crc"}, 64'(get_crc(sel)), 64'(ec));
    chk({tag, "_len"}, 64'(get_len(sel)), 64'(el));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, "_hold_valid"}, 64'(get_mv(sel)), 64'd1);
      chk({tag, "_hold_crc"}, 64'(get_crc(sel)), 64'(ec));
      chk({tag, "_hold_len"}, 64'(get_len(sel)), 64'(el));
      chk({tag, "_hold_ready"}, 64'(get_rdy(sel)), 64'd0);
    end
    if (sel) b_m_ready = 1'b1; else a_m_ready = 1'b1;
    @(negedge clk);
    if (sel) b_m_ready = 1'b0; else a_m_ready = 1'b0;
    chk({tag, "_valid_falls"}, 64'(get_mv(sel)), 64'd0);
    chk({tag, "_ready_back"}, 64'(get_rdy(sel)), 64'd1);
  endtask

  // Send a message as beats; junk sets ignored keep bits above the first zero,
  // k0 appends an empty last beat (message length must fill whole beats).
  task automatic send_msg(input bit sel, input u8 msg[$], input bit junk, input bit k0,
                          input int hold, input logic [31:0] ec, input string tag);
    int w, n, nb, r, lat;
    logic [31:0] d;
    logic [3:0]  kp;
    logic        last;
    w  = sel ? 4 : 1;
    n  = msg.size();
    nb = (n + w - 1) / w;
    r  = w;
    for (int b = 0; b < nb; b++) begin
      r = n - b * w;
      if (r > w) r = w;
      d = $urandom;
      for (int j = 0; j < r; j++) d[8*j +: 8] = msg[b*w + j];
      last = (b == nb - 1) && !k0;
      if (!last) kp = 4'($urandom);
      else if (r == w) kp = sel ? 4'hF : 4'h1;
      else begin
        kp = 4'((1 << r) - 1);
        if (junk) kp = kp | (4'($urandom) & 4'(32'hF << (r + 1)));
      end
      drive_beat(sel, d, kp, last, tag);
    end
    if (k0) begin
      d  = $urandom;
      kp = junk ? (4'($urandom) & 4'hE) : 4'h0;
      drive_beat(sel, d, kp, 1'b1, tag);
      lat = 2;
    end else begin
      lat = (r == w) ? 1 : 1 + r;
    end
    expect_result(sel, ec, 32'(n), lat, hold, tag);
  endtask

  initial begin
    u8 msg[$];
    u8 rmsg[$];
    bit sel, k0;
    int n;

    rstn = 1'b0;
    a_clr = 0; a_s_valid = 0; a_s_last = 0; a_s_data = '0; a_s_keep = '0; a_m_ready = 0;
    b_clr = 0; b_s_valid = 0; b_s_last = 0; b_s_data = '0; b_s_keep = '0; b_m_ready = 0;
    for (int i = 1; i <= 9; i++) msg.push_back(8'(8'h30 + i));

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_a_ready", 64'(a_s_ready), 64'd0);
    chk("rst_b_ready", 64'(b_s_ready), 64'd0);
    chk("rst_a_valid", 64'(a_m_valid), 64'd0);
    chk("rst_b_crc", 64'(b_m_crc), 64'd0);
    chk("rst_b_len", 64'(b_m_len), 64'd0);
    rstn = 1'b1;
    #1;
    chk("rdy_after_reset_a", 64'(a_s_ready), 64'd1);
    chk("rdy_after_reset_b", 64'(b_s_ready), 64'd1);

    // Check strings
    send_msg(0, msg, 1'b0, 1'b0, 0, 32'h29B1, "check_ccitt");
    send_msg(1, msg, 1'b0, 1'b0, 0, 32'hCBF43926, "check_crc32");

    // Backpressure then a repeat of the same message
    send_msg(1, msg, 1'b0, 1'b0, 10, 32'hCBF43926, "stall_crc32");
    send_msg(1, msg, 1'b0, 1'b0, 0, 32'hCBF43926, "repeat_crc32");

    // clr mid-message after four bytes
    for (int i = 0; i < 4; i++) drive_beat(0, {24'h0, msg[i]}, 4'h1, 1'b0, "clr_mid");
    @(negedge clk);
    a_s_valid = 1'b0;
    a_clr = 1'b1;
    #1;
    chk("clr_ready_low", 64'(a_s_ready), 64'd0);
    @(negedge clk);
    a_clr = 1'b0;
    #1;
    chk("clr_valid_low", 64'(a_m_valid), 64'd0);
    chk("clr_ready_back", 64'(a_s_ready), 64'd1);
    send_msg(0, msg, 1'b0, 1'b0, 0, 32'h29B1, "after_clr");

    // Reset asserted while draining a partial last beat
    drive_beat(1, 32'h34333231, 4'hF, 1'b0, "rst_tail");
    drive_beat(1, 32'hAB373635, 4'b0111, 1'b1, "rst_tail");
    @(negedge clk);
    @(negedge clk);
    b_s_valid = 1'b0;
    b_s_last = 1'b0;
    rstn = 1'b0;
    #1;
    chk("rst_tail_valid", 64'(b_m_valid), 64'd0);
    chk("rst_tail_len", 64'(b_m_len), 64'd0);
    chk("rst_tail_ready", 64'(b_s_ready), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    chk("rst_tail_ready_back", 64'(b_s_ready), 64'd1);
    send_msg(1, msg, 1'b0, 1'b0, 0, 32'hCBF43926, "after_rst");

    // Empty last beat (k = 0) on both instances
    rmsg = msg[0:7];
    send_msg(1, rmsg, 1'b1, 1'b1, 0, ref_crc(1, rmsg), "k0_crc32");
    send_msg(0, rmsg, 1'b1, 1'b1, 0, ref_crc(0, rmsg), "k0_ccitt");

    // Randomised messages against the reference model
    for (int it = 0; it < 16; it++) begin
      sel = it[0];
      n = $urandom_range(1, 20);
      rmsg.delete();
      for (int i = 0; i < n; i++) rmsg.push_back(8'($urandom));
      k0 = ($urandom_range(0, 3) == 0) && ((n % (sel ? 4 : 1)) == 0);
      send_msg(sel, rmsg, 1'b1, k0, $urandom_range(0, 2), ref_crc(sel, rmsg),
               $sformatf("rand%0d", it));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
